// File: rtl/sram_2inst_req_sched_pkg.sv
// Shared types for the two-instance SRAM request scheduler: SRAM command,
// buffered request record and the idle-lane steering helper.
package sram_2inst_req_sched_pkg;

  localparam int SRAM_REQ_TAG_W = 4;
  localparam int SRAM_ADDR_W    = 8;

  typedef struct packed {
    logic [1:0]             dest_ram_id;
    logic [SRAM_ADDR_W-1:0] addr;
  } sram_inst_cmd_t;

  typedef struct packed {
    logic                      wr;
    sram_inst_cmd_t            cmd;
    logic [31:0]               wdata;
    logic [SRAM_REQ_TAG_W-1:0] tag;
  } sram_req_t;

  // The SRAM pair steers lane b from lane a's instance bit, so an idle lane
  // must point at the instance the active lane is not using.
  function automatic sram_inst_cmd_t steer_cmd(input sram_inst_cmd_t c);
    sram_inst_cmd_t r;
    r = c;
    r.dest_ram_id[0] = ~c.dest_ram_id[0];
    return r;
  endfunction

endpackage

// File: rtl/sram_2inst_req_sched_if.sv
// One request/SRAM/response lane of the scheduler; the scheduler is the slave,
// the requester plus SRAM pair side is the master.
interface sram_2inst_req_sched_if;
  import sram_2inst_req_sched_pkg::*;

  logic                      req_vld;
  logic                      req_rdy;
  logic                      req_wr;
  sram_inst_cmd_t            req_cmd;
  logic [31:0]               req_wdata;
  logic [SRAM_REQ_TAG_W-1:0] req_tag;
  logic                      read_vld;
  sram_inst_cmd_t            read_cmd;
  logic                      write_vld;
  sram_inst_cmd_t            write_cmd;
  logic [31:0]               wr_data;
  logic [31:0]               rd_data;
  logic                      resp_vld;
  logic [31:0]               resp_data;
  logic [SRAM_REQ_TAG_W-1:0] resp_tag;

  modport slave (
    input  req_vld, req_wr, req_cmd, req_wdata, req_tag, rd_data,
    output req_rdy, read_vld, read_cmd, write_vld, write_cmd, wr_data,
           resp_vld, resp_data, resp_tag
  );

  modport master (
    output req_vld, req_wr, req_cmd, req_wdata, req_tag, rd_data,
    input  req_rdy, read_vld, read_cmd, write_vld, write_cmd, wr_data,
           resp_vld, resp_data, resp_tag
  );

endinterface

// File: rtl/sram_2inst_req_sched_fifo.sv
// Per-lane in-order request buffer; push is ignored when full even if a pop
// happens in the same cycle, and the head is visible the cycle after a push.
module sram_req_fifo
  import sram_2inst_req_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  sram_req_t                push_dat_i,
  input  logic                     pop_i,
  output sram_req_t                head_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  sram_req_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/sram_2inst_req_sched.sv
// Two-lane request scheduler in front of the SRAM pair: one op per instance per
// cycle, round-robin on instance conflicts, read responses one cycle after issue.
module sram_2inst_req_sched
  import sram_2inst_req_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_2inst_req_sched_if.slave  lane_a_if,
  sram_2inst_req_sched_if.slave  lane_b_if
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  sram_req_t                 req_a, req_b, head_a, head_b;
  logic                      full_a, full_b, empty_a, empty_b;
  logic [CW-1:0]             cnt_a, cnt_b;
  logic                      push_a, push_b;
  logic                      conflict;
  logic                      pop_a, pop_b;
  logic                      rd_a, rd_b, wr_a, wr_b;
  logic                      rr_q, rr_d;
  logic                      rd_pend_a_q, rd_pend_a_d, rd_pend_b_q, rd_pend_b_d;
  logic [SRAM_REQ_TAG_W-1:0] tag_a_q, tag_a_d, tag_b_q, tag_b_d;

  assign req_a = '{wr: lane_a_if.req_wr, cmd: lane_a_if.req_cmd,
                   wdata: lane_a_if.req_wdata, tag: lane_a_if.req_tag};
  assign req_b = '{wr: lane_b_if.req_wr, cmd: lane_b_if.req_cmd,
                   wdata: lane_b_if.req_wdata, tag: lane_b_if.req_tag};

  assign lane_a_if.req_rdy = (cnt_a != FULL_CNT);
  assign lane_b_if.req_rdy = (cnt_b != FULL_CNT);
  assign push_a = lane_a_if.req_vld && !full_a;
  assign push_b = lane_b_if.req_vld && !full_b;

  sram_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .push_i(push_a), .push_dat_i(req_a), .pop_i(pop_a),
    .head_dat_o(head_a), .full_o(full_a), .empty_o(empty_a), .count_o(cnt_a)
  );

  sram_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .push_i(push_b), .push_dat_i(req_b), .pop_i(pop_b),
    .head_dat_o(head_b), .full_o(full_b), .empty_o(empty_b), .count_o(cnt_b)
  );

  // Any two ops on one instance collide, whatever their read/write mix.
  always_comb begin
    conflict = !empty_a && !empty_b &&
               (head_a.cmd.dest_ram_id[0] == head_b.cmd.dest_ram_id[0]);
    pop_a    = !empty_a && (!conflict || !rr_q);
    pop_b    = !empty_b && (!conflict || rr_q);
    rr_d     = rr_q ^ conflict;
    rd_a     = pop_a && !head_a.wr;
    wr_a     = pop_a && head_a.wr;
    rd_b     = pop_b && !head_b.wr;
    wr_b     = pop_b && head_b.wr;
  end

  always_comb begin
    lane_a_if.read_vld  = rd_a;
    lane_b_if.read_vld  = rd_b;
    lane_a_if.write_vld = wr_a;
    lane_b_if.write_vld = wr_b;
    lane_a_if.read_cmd  = '0;
    lane_b_if.read_cmd  = '0;
    lane_a_if.write_cmd = '0;
    lane_b_if.write_cmd = '0;
    if (rd_a)      lane_a_if.read_cmd = head_a.cmd;
    else if (rd_b) lane_a_if.read_cmd = steer_cmd(head_b.cmd);
    if (rd_b)      lane_b_if.read_cmd = head_b.cmd;
    else if (rd_a) lane_b_if.read_cmd = steer_cmd(head_a.cmd);
    if (wr_a)      lane_a_if.write_cmd = head_a.cmd;
    else if (wr_b) lane_a_if.write_cmd = steer_cmd(head_b.cmd);
    if (wr_b)      lane_b_if.write_cmd = head_b.cmd;
    else if (wr_a) lane_b_if.write_cmd = steer_cmd(head_a.cmd);
    lane_a_if.wr_data = wr_a ? head_a.wdata : '0;
    lane_b_if.wr_data = wr_b ? head_b.wdata : '0;
  end

  always_comb begin
    rd_pend_a_d = rd_a;
    rd_pend_b_d = rd_b;
    tag_a_d     = rd_a ? head_a.tag : tag_a_q;
    tag_b_d     = rd_b ? head_b.tag : tag_b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= 1'b0;
      rd_pend_a_q <= 1'b0;
      rd_pend_b_q <= 1'b0;
      tag_a_q     <= '0;
      tag_b_q     <= '0;
    end else begin
      rr_q        <= rr_d;
      rd_pend_a_q <= rd_pend_a_d;
      rd_pend_b_q <= rd_pend_b_d;
      tag_a_q     <= tag_a_d;
      tag_b_q     <= tag_b_d;
    end
  end

  // SRAM read data arrives exactly one cycle after issue, so it is forwarded unregistered.
  assign lane_a_if.resp_vld  = rd_pend_a_q;
  assign lane_a_if.resp_data = lane_a_if.rd_data;
  assign lane_a_if.resp_tag  = tag_a_q;
  assign lane_b_if.resp_vld  = rd_pend_b_q;
  assign lane_b_if.resp_data = lane_b_if.rd_data;
  assign lane_b_if.resp_tag  = tag_b_q;

endmodule

// File: tb/tb_sram_2inst_req_sched.sv
// Directed bench for sram_2inst_req_sched: per-cycle vector table plus
// hand sequences for backpressure and mid-operation reset.
module tb_sram_2inst_req_sched;
  import sram_2inst_req_sched_pkg::*;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_2inst_req_sched_if a_if ();
  sram_2inst_req_sched_if b_if ();

  sram_2inst_req_sched #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lane_a_if (a_if),
    .lane_b_if (b_if)
  );

  typedef struct {
    logic        va, wa, ia;
    logic [3:0]  ta;
    logic        vb, wb, ib;
    logic [3:0]  tgb;
    logic [11:0] flags;  // rdy_a rdy_b rva wva rvb wvb rca0 wca0 rcb0 wcb0 respa respb
    logic [3:0]  etag_a, etag_b;
    logic [31:0] ewd_a, eda, edb;
  } vec_t;

  localparam int NVEC = 22;
  vec_t       vecs [NVEC];
  int         checks = 0;
  int         errors = 0;
  logic       collect = 1'b0;
  logic [3:0] tags_a [$];

  function automatic logic [31:0] sram_word(input sram_inst_cmd_t c);
    return 32'h5A00_0000 | {23'd0, c.dest_ram_id[0], c.addr};
  endfunction

  // Registered SRAM pair: data from the addressed instance one cycle after a read.
  always @(posedge clk) begin
    a_if.rd_data <= a_if.read_vld ? sram_word(a_if.read_cmd) : 32'h0;
    b_if.rd_data <= b_if.read_vld ? sram_word(b_if.read_cmd) : 32'h0;
  end

  always @(negedge clk) begin
    if (collect && a_if.resp_vld) tags_a.push_back(a_if.resp_tag);
  end

  function automatic vec_t mk(input logic va, wa, ia, input logic [3:0] ta,
                              input logic vb, wb, ib, input logic [3:0] tgb,
                              input logic [11:0] fl, input logic [3:0] eta, etb,
                              input logic [31:0] ewd, eda, edb);
    vec_t v;
    v.va = va; v.wa = wa; v.ia = ia; v.ta = ta;
    v.vb = vb; v.wb = wb; v.ib = ib; v.tgb = tgb;
    v.flags = fl; v.etag_a = eta; v.etag_b = etb;
    v.ewd_a = ewd; v.eda = eda; v.edb = edb;
    return v;
  endfunction

  function automatic logic [115:0] obs();
    return {a_if.req_rdy, b_if.req_rdy, a_if.read_vld, a_if.write_vld,
            b_if.read_vld, b_if.write_vld,
            a_if.read_cmd.dest_ram_id[0], a_if.write_cmd.dest_ram_id[0],
            b_if.read_cmd.dest_ram_id[0], b_if.write_cmd.dest_ram_id[0],
            a_if.resp_vld, b_if.resp_vld, a_if.resp_tag, b_if.resp_tag,
            a_if.wr_data, a_if.resp_data, b_if.resp_data};
  endfunction

  task automatic check(input string name, input logic [115:0] act, input logic [115:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic va, wa, ia, input logic [3:0] ta,
                       input logic vb, wb, ib, input logic [3:0] tgb);
    a_if.req_vld   = va;
    a_if.req_wr    = wa;
    a_if.req_cmd   = '{dest_ram_id: {1'b0, ia}, addr: {4'h0, ta}};
    a_if.req_wdata = 32'hBEEF_0000 | {28'd0, ta};
    a_if.req_tag   = ta;
    b_if.req_vld   = vb;
    b_if.req_wr    = wb;
    b_if.req_cmd   = '{dest_ram_id: {1'b0, ib}, addr: {4'h0, tgb}};
    b_if.req_wdata = 32'hBEEF_0000 | {28'd0, tgb};
    b_if.req_tag   = tgb;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 4'h0, 0, 0, 0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic any_vld;

    // Reads use addr = tag, so each expected word is 5A00_0{id}{tag}.
    vecs[0]  = mk(1,0,1,4'h3, 1,0,0,4'h5, 12'b11_0000_0000_00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    vecs[1]  = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_1010_1000_00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    vecs[2]  = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_0000_0000_11, 4'h3, 4'h5, 32'h0, 32'h5A00_0103, 32'h5A00_0005);
    vecs[3]  = mk(1,0,1,4'h1, 1,0,1,4'h2, 12'b11_0000_0000_00, 4'h3, 4'h5, 32'h0, 32'h0, 32'h0);
    vecs[4]  = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_1000_1000_00, 4'h3, 4'h5, 32'h0, 32'h0, 32'h0);
    vecs[5]  = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_0010_0010_10, 4'h1, 4'h5, 32'h0, 32'h5A00_0101, 32'h0);
    vecs[6]  = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_0000_0000_01, 4'h1, 4'h2, 32'h0, 32'h0, 32'h5A00_0102);
    vecs[7]  = mk(1,0,1,4'h6, 1,0,1,4'h7, 12'b11_0000_0000_00, 4'h1, 4'h2, 32'h0, 32'h0, 32'h0);
    vecs[8]  = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_0010_0010_00, 4'h1, 4'h2, 32'h0, 32'h0, 32'h0);
    vecs[9]  = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_1000_1000_01, 4'h1, 4'h7, 32'h0, 32'h0, 32'h5A00_0107);
    vecs[10] = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_0000_0000_10, 4'h6, 4'h7, 32'h0, 32'h5A00_0106, 32'h0);
    vecs[11] = mk(1,0,1,4'h8, 1,0,1,4'h9, 12'b11_0000_0000_00, 4'h6, 4'h7, 32'h0, 32'h0, 32'h0);
    vecs[12] = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_1000_1000_00, 4'h6, 4'h7, 32'h0, 32'h0, 32'h0);
    vecs[13] = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_0010_0010_10, 4'h8, 4'h7, 32'h0, 32'h5A00_0108, 32'h0);
    vecs[14] = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_0000_0000_01, 4'h8, 4'h9, 32'h0, 32'h0, 32'h5A00_0109);
    vecs[15] = mk(0,0,0,4'h0, 1,0,0,4'h4, 12'b11_0000_0000_00, 4'h8, 4'h9, 32'h0, 32'h0, 32'h0);
    vecs[16] = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_0010_1000_00, 4'h8, 4'h9, 32'h0, 32'h0, 32'h0);
    vecs[17] = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_0000_0000_01, 4'h8, 4'h4, 32'h0, 32'h0, 32'h5A00_0004);
    vecs[18] = mk(1,1,0,4'hA, 1,0,0,4'hB, 12'b11_0000_0000_00, 4'h8, 4'h4, 32'h0, 32'h0, 32'h0);
    vecs[19] = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_0010_1000_00, 4'h8, 4'h4, 32'h0, 32'h0, 32'h0);
    vecs[20] = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_0100_0001_01, 4'h8, 4'hB, 32'hBEEF_000A, 32'h0, 32'h5A00_000B);
    vecs[21] = mk(0,0,0,4'h0, 0,0,0,4'h0, 12'b11_0000_0000_00, 4'h8, 4'hB, 32'h0, 32'h0, 32'h0);

    // Reset state, sampled while reset is still asserted.
    rst_n = 1'b0;
    drive(0, 0, 0, 4'h0, 0, 0, 0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", obs(), {12'b11_0000_0000_00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0});
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].va, vecs[i].wa, vecs[i].ia, vecs[i].ta,
            vecs[i].vb, vecs[i].wb, vecs[i].ib, vecs[i].tgb);
      @(negedge clk);
      check($sformatf("vec%0d", i), obs(),
            {vecs[i].flags, vecs[i].etag_a, vecs[i].etag_b,
             vecs[i].ewd_a, vecs[i].eda, vecs[i].edb});
    end

    // Backpressure: lane a fills to 4 while lane b's conflicts halve its drain rate.
    do_reset();
    collect = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 1'b1, (c < 8) ? 4'(c) : 4'd7,
            (c < 3), 1'b0, 1'b1, 4'(8 + c));
      @(negedge clk);
      if (c == 6) check("bp_rdy_before_full", 116'(a_if.req_rdy), 116'(1));
      if (c == 7) check("bp_full_pop_no_accept", 116'({a_if.req_rdy, a_if.read_vld}), 116'(2'b01));
      if (c == 8) check("bp_rdy_after_pop", 116'(a_if.req_rdy), 116'(1));
    end
    @(posedge clk);
    #1;
    drive(0, 0, 0, 4'h0, 0, 0, 0, 4'h0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    collect = 1'b0;
    check("bp_resp_count", 116'(tags_a.size()), 116'(8));
    for (int i = 0; i < tags_a.size() && i < 8; i++)
      check($sformatf("bp_tag%0d", i), 116'(tags_a[i]), 116'(i));

    // Reset mid-operation: one read pending on a, three requests queued.
    do_reset();
    @(posedge clk);
    #1;
    drive(1, 0, 1, 4'h1, 1, 0, 1, 4'h2);
    @(posedge clk);
    #1;
    drive(1, 0, 1, 4'h3, 1, 0, 1, 4'h4);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 4'h0, 0, 0, 0, 4'h0);
    #1;
    check("rst_pre_pending", 116'({a_if.resp_vld, a_if.resp_tag, b_if.read_vld}), 116'({1'b1, 4'h1, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("rst_vld_cleared", 116'({a_if.resp_vld, b_if.resp_vld, a_if.read_vld, a_if.write_vld,
                                   b_if.read_vld, b_if.write_vld}), 116'(0));
    check("rst_rdy", 116'({a_if.req_rdy, b_if.req_rdy}), 116'(2'b11));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    any_vld = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      any_vld = any_vld | a_if.read_vld | a_if.write_vld | b_if.read_vld | b_if.write_vld |
                a_if.resp_vld | b_if.resp_vld;
    end
    check("rst_no_stale_issue", 116'(any_vld), 116'(0));
    check("rst_post_state", 116'({a_if.req_rdy, b_if.req_rdy, a_if.resp_tag, b_if.resp_tag}),
          116'({2'b11, 4'h0, 4'h0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
